encoder_4to2_rr: RTL and testbench

//  - Registered 4-to-2 encoder: the inverse of the 2-to-4 select decoder.
//  - Samples a 4-bit request vector, picks one active line and emits its 2-bit index.
//  - The index is held under a valid/ready handshake until the consumer accepts it.
//  - Round-robin priority gives every request line fair service.
//  - Sits in front of the 2-to-4 decoder: encoded index -> select, so the pair round-trips.
//  - Polarity matches the decoder: enable=1 disables.

---
 rtl/encoder_4to2_rr_if.sv | 21 ++
 rtl/encoder_4to2_rr.sv | 81 ++++++++
 tb/tb_encoder_4to2_rr.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/encoder_4to2_rr_if.sv
// Request/grant bundle for the registered 4-to-2 encoder.
// master drives requests and accepts codes; slave is the encoder.
interface encoder_4to2_rr_if;
  logic       enable;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] code;
  logic       out_valid;
  logic       multi;
  logic [3:0] onehot;

  modport master (
    output enable, req, out_ready,
    input  code, out_valid, multi, onehot
  );

  modport slave (
    input  enable, req, out_ready,
    output code, out_valid, multi, onehot
  );
endinterface

// File: rtl/encoder_4to2_rr.sv
// Registered 4-to-2 encoder with round-robin or fixed priority.
// The granted index is held under a valid/ready handshake.
module encoder_4to2_rr #(
  parameter bit         RR_EN     = 1'b1,
  parameter logic [1:0] PTR_RESET = 2'b00
) (
  input logic              clk,
  input logic              rst,
  encoder_4to2_rr_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] code_q;
  logic       valid_q;
  logic       multi_q;
  logic [3:0] onehot_q;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       many;

  // Scan starts at ptr for round-robin; at index 0 for fixed priority.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = RR_EN ? 2'(ptr + 2'(i)) : 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign many = (bus.req & (bus.req - 4'd1)) != 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      code_q   <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.enable && found) begin
            code_q   <= win;
            onehot_q <= 4'b0001 << win;
            multi_q  <= many;
            valid_q  <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // out_valid is always 1 here, so out_ready alone means acceptance.
          if (bus.out_ready) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            if (RR_EN) ptr <= code_q + 2'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code      = code_q;
  assign bus.out_valid = valid_q;
  assign bus.multi     = multi_q;
  assign bus.onehot    = onehot_q;

endmodule

// File: tb/tb_encoder_4to2_rr.sv
// Directed bench for encoder_4to2_rr: one round-robin and one fixed-priority instance.
module tb_encoder_4to2_rr;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  encoder_4to2_rr_if bus_rr ();
  encoder_4to2_rr_if bus_fp ();

  encoder_4to2_rr #(.RR_EN(1'b1), .PTR_RESET(2'b00)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr.slave)
  );

  encoder_4to2_rr #(.RR_EN(1'b0), .PTR_RESET(2'b10)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_rr.enable = 1'b0; bus_rr.req = 4'b0000; bus_rr.out_ready = 1'b0;
    bus_fp.enable = 1'b0; bus_fp.req = 4'b0000; bus_fp.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b0 || bus_rr.code !== 2'b00 || bus_rr.onehot !== 4'b0000 || bus_rr.multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got v=%b c=%b oh=%b m=%b required v=0 c=00 oh=0000 m=0",
               bus_rr.out_valid, bus_rr.code, bus_rr.onehot, bus_rr.multi);
    end
    rst = 1'b0;
    // Move ptr to 11, then capture 1111 from ptr=11 and hold it.
    bus_rr.req = 4'b0100; bus_rr.out_ready = 1'b1;
    step();
    bus_rr.req = 4'b0000;
    step();
    bus_rr.req = 4'b1111; bus_rr.out_ready = 1'b0;
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_hold: got v=%b c=%b required v=1 c=11", bus_rr.out_valid, bus_rr.code);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus_rr.out_valid !== 1'b0 || bus_rr.code !== 2'b00 || bus_rr.onehot !== 4'b0000 || bus_rr.multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got v=%b c=%b oh=%b m=%b required v=0 c=00 oh=0000 m=0",
               bus_rr.out_valid, bus_rr.code, bus_rr.onehot, bus_rr.multi);
    end
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b00 || bus_rr.multi !== 1'b1) begin
      errors++;
      $display("FAIL reset_ptr: got v=%b c=%b m=%b required v=1 c=00 m=1", bus_rr.out_valid, bus_rr.code, bus_rr.multi);
    end
    bus_rr.req = 4'b0000; bus_rr.out_ready = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus_rr.enable = 1'b0; bus_rr.req = 4'b0100; bus_rr.out_ready = 1'b1;
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b10 || bus_rr.onehot !== 4'b0100 || bus_rr.multi !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got v=%b c=%b oh=%b m=%b required v=1 c=10 oh=0100 m=0",
               bus_rr.out_valid, bus_rr.code, bus_rr.onehot, bus_rr.multi);
    end
    bus_rr.req = 4'b0000;
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b0 || bus_rr.onehot !== 4'b0000 || bus_rr.code !== 2'b10) begin
      errors++;
      $display("FAIL single_accept: got v=%b oh=%b c=%b required v=0 oh=0000 c=10",
               bus_rr.out_valid, bus_rr.onehot, bus_rr.code);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_code [5];
    logic [3:0] exp_oh;
    exp_code = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus_rr.enable = 1'b0; bus_rr.req = 4'b1111; bus_rr.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_oh = 4'b0001 << exp_code[k];
      checks++;
      if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== exp_code[k] || bus_rr.multi !== 1'b1 || bus_rr.onehot !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant%0d: got v=%b c=%b m=%b oh=%b required v=1 c=%b m=1 oh=%b",
                 k, bus_rr.out_valid, bus_rr.code, bus_rr.multi, bus_rr.onehot, exp_code[k], exp_oh);
      end
      step();
      checks++;
      if (bus_rr.out_valid !== 1'b0 || bus_rr.onehot !== 4'b0000 || bus_rr.multi !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: got v=%b oh=%b m=%b required v=0 oh=0000 m=0",
                 k, bus_rr.out_valid, bus_rr.onehot, bus_rr.multi);
      end
    end
    bus_rr.req = 4'b0000;
  endtask

  task automatic test_fixed_priority();
    bus_fp.enable = 1'b0; bus_fp.req = 4'b1010; bus_fp.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus_fp.out_valid !== 1'b1 || bus_fp.code !== 2'b01 || bus_fp.multi !== 1'b1 || bus_fp.onehot !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_grant%0d: got v=%b c=%b m=%b oh=%b required v=1 c=01 m=1 oh=0010",
                 k, bus_fp.out_valid, bus_fp.code, bus_fp.multi, bus_fp.onehot);
      end
      step();
    end
    bus_fp.req = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_rr.enable = 1'b0; bus_rr.req = 4'b0001; bus_rr.out_ready = 1'b0;
    step();
    bus_rr.req = 4'b1000; bus_rr.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b00 || bus_rr.onehot !== 4'b0001 || bus_rr.multi !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b c=%b oh=%b m=%b required v=1 c=00 oh=0001 m=0",
                 k, bus_rr.out_valid, bus_rr.code, bus_rr.onehot, bus_rr.multi);
      end
    end
    bus_rr.out_ready = 1'b1; bus_rr.enable = 1'b0; bus_rr.req = 4'b0011;
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got v=%b required v=0", bus_rr.out_valid);
    end
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b01 || bus_rr.multi !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_ptr: got v=%b c=%b m=%b required v=1 c=01 m=1", bus_rr.out_valid, bus_rr.code, bus_rr.multi);
    end
    bus_rr.req = 4'b0000;
    step();
  endtask

  task automatic test_enable_empty();
    // ptr is 10 after the previous acceptance of code 01.
    bus_rr.enable = 1'b1; bus_rr.req = 4'b1111; bus_rr.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        bus_rr.enable = 1'b0; bus_rr.req = 4'b0000;
      end
      step();
      checks++;
      if (bus_rr.out_valid !== 1'b0 || bus_rr.onehot !== 4'b0000) begin
        errors++;
        $display("FAIL en_empty%0d: got v=%b oh=%b required v=0 oh=0000", k, bus_rr.out_valid, bus_rr.onehot);
      end
    end
    bus_rr.req = 4'b1111;
    step();
    checks++;
    if (bus_rr.out_valid !== 1'b1 || bus_rr.code !== 2'b10) begin
      errors++;
      $display("FAIL en_ptr_kept: got v=%b c=%b required v=1 c=10", bus_rr.out_valid, bus_rr.code);
    end
    bus_rr.req = 4'b0000;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_enable_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
